// File: rtl/key_pulse_controller_if.sv
// Key pulse controller bus: raw key levels in, debounced
// levels, command pulse, latched index and busy flag out.
interface key_pulse_controller_if #(
    parameter int NUM_KEYS = 2,
    parameter int IDX_W    = 1
);
    logic [NUM_KEYS-1:0] key_in;
    logic [NUM_KEYS-1:0] key_pulse;
    logic [NUM_KEYS-1:0] key_level;
    logic [IDX_W-1:0]    key_idx;
    logic                busy;

    modport master (
        output key_in,
        input  key_pulse,
        input  key_level,
        input  key_idx,
        input  busy
    );

    modport slave (
        input  key_in,
        output key_pulse,
        output key_level,
        output key_idx,
        output busy
    );
endinterface

// File: rtl/key_pulse_controller.sv
// Key synchronizer, per-channel debouncer and one-pulse-per-press FSM.
// Optional held-key auto repeat enabled by macro KEY_AUTO_REPEAT_EN.
module key_pulse_controller #(
    parameter int NUM_KEYS        = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_CYCLES   = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    key_pulse_controller_if.slave bus
);
    localparam int IDX_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    logic [NUM_KEYS-1:0] sync1_q;
    logic [NUM_KEYS-1:0] sync2_q;
    logic [CNT_W-1:0]    cnt_q [NUM_KEYS];
    logic [CNT_W-1:0]    cnt_d [NUM_KEYS];
    logic [NUM_KEYS-1:0] level_q;
    logic [NUM_KEYS-1:0] level_d;

    state_t              state_q;
    state_t              state_d;
    logic [IDX_W-1:0]    idx_q;
    logic [IDX_W-1:0]    idx_d;
    logic [IDX_W-1:0]    low_idx;
    logic [NUM_KEYS-1:0] pulse_q;
    logic [NUM_KEYS-1:0] pulse_d;
    logic                busy_q;
    logic                busy_d;

`ifdef KEY_AUTO_REPEAT_EN
    localparam int RPT_W = $clog2(REPEAT_CYCLES);
    localparam logic [RPT_W-1:0] RPT_MAX = RPT_W'(REPEAT_CYCLES - 1);
    logic [RPT_W-1:0] rpt_q;
    logic [RPT_W-1:0] rpt_d;
`endif

    // Two-flop synchronizer on the raw asynchronous key levels
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= bus.key_in;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: count cycles the synced level differs, flip level at limit
    always_comb begin
        level_d = level_q;
        for (int i = 0; i < NUM_KEYS; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != level_q[i]) begin
                if (cnt_q[i] + CNT_W'(1) == DB_MAX) begin
                    level_d[i] = ~level_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Debounce counter and debounced level registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                cnt_q[i] <= '0;
            end
            level_q <= '0;
        end else begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            level_q <= level_d;
        end
    end

    // Lowest-index priority pick among debounced pressed keys
    always_comb begin
        low_idx = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (level_q[i]) begin
                low_idx = IDX_W'(i);
            end
        end
    end

    // Next state, latched index and registered-output next values
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
`ifdef KEY_AUTO_REPEAT_EN
        rpt_d   = '0;
`endif
        unique case (state_q)
            IDLE: begin
                if (|level_q) begin
                    idx_d   = low_idx;
                    state_d = PULSE;
                end
            end
            PULSE: begin
                state_d = HOLD;
            end
            HOLD: begin
`ifdef KEY_AUTO_REPEAT_EN
                rpt_d = rpt_q + RPT_W'(1);
                if (!(|level_q)) begin
                    state_d = IDLE;
                end else if (level_q[idx_q] && rpt_q == RPT_MAX) begin
                    state_d = PULSE;
                end
`else
                if (!(|level_q)) begin
                    state_d = IDLE;
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        pulse_d = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            pulse_d[i] = (state_d == PULSE) && (idx_d == IDX_W'(i));
        end
        busy_d = (state_d != IDLE);
    end

    // FSM state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            pulse_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pulse_q <= pulse_d;
            busy_q  <= busy_d;
        end
    end

`ifdef KEY_AUTO_REPEAT_EN
    // Repeat interval counter, cleared outside HOLD
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_q <= '0;
        end else begin
            rpt_q <= rpt_d;
        end
    end
`endif

    assign bus.key_pulse = pulse_q;
    assign bus.key_level = level_q;
    assign bus.key_idx   = idx_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_key_pulse_controller.sv
// Directed bench for key_pulse_controller, NUM_KEYS=2,
// DEBOUNCE_CYCLES=4, REPEAT_CYCLES=10.
module tb_key_pulse_controller;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    int nvec = 0;
    int nerr = 0;
    int pcnt = 0;
    int p0 = 0;
    bit busy_seen = 1'b0;

`ifdef KEY_AUTO_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    key_pulse_controller_if #(.NUM_KEYS(2), .IDX_W(1)) bus ();

    key_pulse_controller #(
        .NUM_KEYS(2),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_CYCLES(10)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.key_pulse != 2'b00) begin
            pcnt++;
            chk("onehot", 32'($countones(bus.key_pulse)), 32'd1);
        end
        if (bus.busy) busy_seen = 1'b1;
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        bus.key_in = 2'b00;
        step(3);
        chk("rst_pulse", 32'(bus.key_pulse), 32'd0);
        chk("rst_level", 32'(bus.key_level), 32'd0);
        chk("rst_idx", 32'(bus.key_idx), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        rst_n = 1'b1;
        step(2);

        // single clean press of key 0
        p0 = pcnt;
        bus.key_in = 2'b01;
        step(6);
        chk("t1_level", 32'(bus.key_level), 32'h1);
        chk("t1_early", 32'(bus.key_pulse), 32'h0);
        chk("t1_busy0", 32'(bus.busy), 32'd0);
        step(1);
        chk("t1_pulse", 32'(bus.key_pulse), 32'h1);
        chk("t1_idx", 32'(bus.key_idx), 32'd0);
        chk("t1_busy1", 32'(bus.busy), 32'd1);
        step(1);
        chk("t1_off", 32'(bus.key_pulse), 32'h0);
        bus.key_in = 2'b00;
        step(6);
        chk("t1_rlevel", 32'(bus.key_level), 32'h0);
        chk("t1_rbusy", 32'(bus.busy), 32'd1);
        step(1);
        chk("t1_idle", 32'(bus.busy), 32'd0);
        chk("t1_count", 32'(pcnt - p0), 32'd1);

        // three-cycle glitch on key 1
        p0 = pcnt;
        busy_seen = 1'b0;
        bus.key_in = 2'b10;
        step(3);
        bus.key_in = 2'b00;
        step(3);
        chk("t2_mid", 32'(bus.key_level), 32'h0);
        step(8);
        chk("t2_level", 32'(bus.key_level), 32'h0);
        chk("t2_count", 32'(pcnt - p0), 32'd0);
        chk("t2_busy", 32'(busy_seen), 32'd0);

        // simultaneous press, then key 1 left held
        p0 = pcnt;
        bus.key_in = 2'b11;
        step(7);
        chk("t3_pulse", 32'(bus.key_pulse), 32'h1);
        chk("t3_idx", 32'(bus.key_idx), 32'd0);
        step(1);
        bus.key_in = 2'b10;
        step(20);
        chk("t3_level", 32'(bus.key_level), 32'h2);
        chk("t3_busy", 32'(bus.busy), 32'd1);
        chk("t3_count", 32'(pcnt - p0), 32'd1);
        bus.key_in = 2'b00;
        step(8);
        chk("t3_idle", 32'(bus.busy), 32'd0);
        chk("t3_count2", 32'(pcnt - p0), 32'd1);

        // key 1 alone after full release
        bus.key_in = 2'b10;
        step(6);
        chk("t4_early", 32'(bus.key_pulse), 32'h0);
        step(1);
        chk("t4_pulse", 32'(bus.key_pulse), 32'h2);
        chk("t4_idx", 32'(bus.key_idx), 32'd1);
        step(2);
        bus.key_in = 2'b00;
        step(8);
        chk("t4_idle", 32'(bus.busy), 32'd0);

        // reset asserted during PULSE, key held through reset
        bus.key_in = 2'b01;
        step(7);
        chk("t5_pulse", 32'(bus.key_pulse), 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t5_apulse", 32'(bus.key_pulse), 32'h0);
        chk("t5_abusy", 32'(bus.busy), 32'd0);
        chk("t5_alevel", 32'(bus.key_level), 32'h0);
        step(2);
        rst_n = 1'b1;
        p0 = pcnt;
        step(6);
        chk("t5_early", 32'(bus.key_pulse), 32'h0);
        step(1);
        chk("t5_repulse", 32'(bus.key_pulse), 32'h1);
        step(2);
        bus.key_in = 2'b00;
        step(8);
        chk("t5_idle", 32'(bus.busy), 32'd0);
        chk("t5_count", 32'(pcnt - p0), 32'd1);

        // key 1 held 40 cycles after its first pulse
        p0 = pcnt;
        bus.key_in = 2'b10;
        step(7);
        chk("t6_pulse", 32'(bus.key_pulse), 32'h2);
        step(10);
        chk("t6_gap", 32'(bus.key_pulse), 32'h0);
        step(1);
        chk("t6_rep", 32'(bus.key_pulse), REP ? 32'h2 : 32'h0);
        step(29);
        chk("t6_count", 32'(pcnt - p0), REP ? 32'd4 : 32'd1);
        bus.key_in = 2'b00;
        step(8);
        chk("t6_idle", 32'(bus.busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
